// File: rtl/ascon_ctrl_fsm.sv
// ascon_ctrl_fsm: Ascon-128 encryption sequencer (init, AD, PT, final) driving the permutation
// datapath one round per clock, with a request/valid handshake per data block.
module ascon_ctrl_fsm #(
  parameter int PA_ROUNDS    = 12,
  parameter int PB_ROUNDS    = 6,
  parameter int NB_AD_BLOCKS = 1,
  parameter int NB_PT_BLOCKS = 3,
  parameter int RND_W        = 4,
  parameter int BLK_W        = 4
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic             data_valid_i,
  output logic             data_req_o,
  output logic [RND_W-1:0] round_o,
  output logic [BLK_W-1:0] block_o,
  output logic             init_o,
  output logic             en_state_o,
  output logic             xor_data_b_o,
  output logic             xor_key_b_o,
  output logic             xor_key_e_o,
  output logic             xor_lsb_e_o,
  output logic             en_cipher_o,
  output logic             en_tag_o,
  output logic             busy_o,
  output logic             end_o
);
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FINAL, S_DONE} state_t;
  localparam bit               HAS_AD  = NB_AD_BLOCKS > 0;
  localparam logic [RND_W-1:0] A_LAST  = RND_W'(PA_ROUNDS - 1);
  localparam logic [RND_W-1:0] B_LAST  = RND_W'(PB_ROUNDS - 1);
  localparam logic [RND_W-1:0] B_OFS   = RND_W'(PA_ROUNDS - PB_ROUNDS);
  localparam logic [BLK_W-1:0] AD_LAST = BLK_W'(HAS_AD ? NB_AD_BLOCKS - 1 : 0);
  localparam logic [BLK_W-1:0] PT_LAST = BLK_W'(NB_PT_BLOCKS - 1);
  state_t           r_state, w_state_nxt;
  logic [RND_W-1:0] r_rnd, w_rnd_nxt;
  logic [BLK_W-1:0] r_blk, w_blk_nxt;
  logic             w_pa, w_pb, w_first, w_last_a, w_last_b, w_ad_last, w_pt_last;
  assign w_pa      = r_state == S_INIT || r_state == S_FINAL;
  assign w_pb      = r_state == S_AD || r_state == S_PT;
  assign w_first   = r_rnd == '0;
  assign w_last_a  = r_rnd == A_LAST;
  assign w_last_b  = r_rnd == B_LAST;
  assign w_ad_last = r_blk == AD_LAST;
  assign w_pt_last = r_blk == PT_LAST;
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      r_state <= S_IDLE;
      r_rnd   <= '0;
      r_blk   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rnd   <= w_rnd_nxt;
      r_blk   <= w_blk_nxt;
    end
  end
  // round counter restarts at 0 whenever a permutation phase ends or no phase is running
  always_comb begin
    w_state_nxt = r_state;
    w_blk_nxt   = r_blk;
    w_rnd_nxt   = (w_pa ? w_last_a : w_pb ? w_last_b : 1'b1) ? '0 : r_rnd + 1'b1;
    case (r_state)
      S_IDLE:    if (start_i) begin
                   w_state_nxt = S_INIT;
                   w_blk_nxt   = '0;
                 end
      S_INIT:    if (w_last_a) w_state_nxt = HAS_AD ? S_WAIT_AD : S_WAIT_PT;
      S_WAIT_AD: if (data_valid_i) w_state_nxt = S_AD;
      S_AD:      if (w_last_b) begin
                   w_state_nxt = w_ad_last ? S_WAIT_PT : S_WAIT_AD;
                   w_blk_nxt   = w_ad_last ? '0 : r_blk + 1'b1;
                 end
      S_WAIT_PT: if (data_valid_i) w_state_nxt = w_pt_last ? S_FINAL : S_PT;
      S_PT:      if (w_last_b) begin
                   w_state_nxt = S_WAIT_PT;
                   w_blk_nxt   = r_blk + 1'b1;
                 end
      S_FINAL:   if (w_last_a) w_state_nxt = S_DONE;
      S_DONE:    begin
                   w_state_nxt = S_IDLE;
                   w_blk_nxt   = '0;
                 end
      default:   begin
                   w_state_nxt = S_IDLE;
                   w_blk_nxt   = '0;
                 end
    endcase
  end
  always_comb begin
    data_req_o   = r_state == S_WAIT_AD || r_state == S_WAIT_PT;
    round_o      = w_pb ? B_OFS + r_rnd : w_pa ? r_rnd : '0;
    block_o      = r_blk;
    init_o       = r_state == S_INIT && w_first;
    en_state_o   = w_pa || w_pb;
    xor_data_b_o = (w_pb || r_state == S_FINAL) && w_first;
    xor_key_b_o  = r_state == S_FINAL && w_first;
    xor_key_e_o  = w_pa && w_last_a;
    xor_lsb_e_o  = (r_state == S_INIT && w_last_a && !HAS_AD) || (r_state == S_AD && w_last_b && w_ad_last);
    en_cipher_o  = (r_state == S_PT || r_state == S_FINAL) && w_first;
    en_tag_o     = r_state == S_FINAL && w_last_a;
    busy_o       = r_state != S_IDLE;
    end_o        = r_state == S_DONE;
  end
endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// tb_ascon_ctrl_fsm: directed bench for ascon_ctrl_fsm with default, no-AD and short-round configs.
module tb_ascon_ctrl_fsm;
  logic clk = 1'b0, resetb = 1'b0, start = 1'b0, valid = 1'b0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  // flag vector bit order: init,en_state,xdb,xkb,xke,xle,cipher,tag,busy,end,req
  localparam int PH_T[10] = '{0, 1, 2, 3, 4, 3, 4, 3, 5, 6};
  localparam int BK_T[10] = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 0};
  logic d_req, d_init, d_ens, d_xdb, d_xkb, d_xke, d_xle, d_ciph, d_tag, d_busy, d_end;
  logic a_req, a_init, a_ens, a_xdb, a_xkb, a_xke, a_xle, a_ciph, a_tag, a_busy, a_end;
  logic s_req, s_init, s_ens, s_xdb, s_xkb, s_xke, s_xle, s_ciph, s_tag, s_busy, s_end;
  logic [3:0] d_round, d_block, a_round, a_block, s_round, s_block;
  logic [10:0] d_fl, a_fl, s_fl;
  assign d_fl = {d_init, d_ens, d_xdb, d_xkb, d_xke, d_xle, d_ciph, d_tag, d_busy, d_end, d_req};
  assign a_fl = {a_init, a_ens, a_xdb, a_xkb, a_xke, a_xle, a_ciph, a_tag, a_busy, a_end, a_req};
  assign s_fl = {s_init, s_ens, s_xdb, s_xkb, s_xke, s_xle, s_ciph, s_tag, s_busy, s_end, s_req};
  ascon_ctrl_fsm u_def (
    .clock_i(clk), .resetb_i(resetb), .start_i(start), .data_valid_i(valid),
    .data_req_o(d_req), .round_o(d_round), .block_o(d_block), .init_o(d_init),
    .en_state_o(d_ens), .xor_data_b_o(d_xdb), .xor_key_b_o(d_xkb), .xor_key_e_o(d_xke),
    .xor_lsb_e_o(d_xle), .en_cipher_o(d_ciph), .en_tag_o(d_tag), .busy_o(d_busy), .end_o(d_end)
  );
  ascon_ctrl_fsm #(.NB_AD_BLOCKS(0)) u_noad (
    .clock_i(clk), .resetb_i(resetb), .start_i(start), .data_valid_i(valid),
    .data_req_o(a_req), .round_o(a_round), .block_o(a_block), .init_o(a_init),
    .en_state_o(a_ens), .xor_data_b_o(a_xdb), .xor_key_b_o(a_xkb), .xor_key_e_o(a_xke),
    .xor_lsb_e_o(a_xle), .en_cipher_o(a_ciph), .en_tag_o(a_tag), .busy_o(a_busy), .end_o(a_end)
  );
  ascon_ctrl_fsm #(.PA_ROUNDS(8), .PB_ROUNDS(4), .NB_PT_BLOCKS(1)) u_short (
    .clock_i(clk), .resetb_i(resetb), .start_i(start), .data_valid_i(valid),
    .data_req_o(s_req), .round_o(s_round), .block_o(s_block), .init_o(s_init),
    .en_state_o(s_ens), .xor_data_b_o(s_xdb), .xor_key_b_o(s_xkb), .xor_key_e_o(s_xke),
    .xor_lsb_e_o(s_xle), .en_cipher_o(s_ciph), .en_tag_o(s_tag), .busy_o(s_busy), .end_o(s_end)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    start = 1'b0;
    resetb = 1'b0;
    step();
    step();
    resetb = 1'b1;
  endtask
  task automatic test_reset();
    start = 1'b1;
    valid = 1'b1;
    resetb = 1'b0;
    step();
    step();
    checks++;
    if ({d_round, d_block, d_fl} !== 19'd0) begin
      errors++;
      $display("FAIL reset_def: got %h expected 0", {d_round, d_block, d_fl});
    end
    checks++;
    if ({a_round, a_block, a_fl} !== 19'd0) begin
      errors++;
      $display("FAIL reset_noad: got %h expected 0", {a_round, a_block, a_fl});
    end
    checks++;
    if ({s_round, s_block, s_fl} !== 19'd0) begin
      errors++;
      $display("FAIL reset_short: got %h expected 0", {s_round, s_block, s_fl});
    end
    start = 1'b0;
    resetb = 1'b1;
    step();
    checks++;
    if (d_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy got %b expected 0", d_busy);
    end
  endtask
  task automatic test_full_flow();
    int len, ciph, tag, ends;
    logic [3:0] er;
    logic [10:0] ef;
    do_reset();
    valid = 1'b1;
    start = 1'b1;
    ciph = 0;
    tag = 0;
    ends = 0;
    step();
    start = 1'b0;
    for (int p = 0; p < 10; p++) begin
      len = (PH_T[p] == 0 || PH_T[p] == 5) ? 12 : (PH_T[p] == 2 || PH_T[p] == 4) ? 6 : 1;
      for (int k = 0; k < len; k++) begin
        er = '0;
        ef = 11'b100;
        case (PH_T[p])
          0: begin er = 4'(k); ef[9] = 1'b1; ef[10] = k == 0; ef[6] = k == 11; end
          1, 3: ef[0] = 1'b1;
          2: begin er = 4'(6 + k); ef[9] = 1'b1; ef[8] = k == 0; ef[5] = k == 5; end
          4: begin er = 4'(6 + k); ef[9] = 1'b1; ef[8] = k == 0; ef[4] = k == 0; end
          5: begin
            er = 4'(k);
            ef[9] = 1'b1;
            ef[8] = k == 0; ef[7] = k == 0; ef[4] = k == 0;
            ef[6] = k == 11; ef[3] = k == 11;
          end
          default: ef[1] = 1'b1;
        endcase
        checks++;
        if ({d_round, d_fl} !== {er, ef} || (PH_T[p] inside {[1:4]} && d_block !== 4'(BK_T[p]))) begin
          errors++;
          $display("FAIL flow p%0d k%0d: got rnd=%0d blk=%0d flags=%b expected rnd=%0d blk=%0d flags=%b",
                   p, k, d_round, d_block, d_fl, er, BK_T[p], ef);
        end
        ciph += int'(d_ciph);
        tag += int'(d_tag);
        ends += int'(d_end);
        step();
      end
    end
    repeat (3) begin
      ends += int'(d_end);
      step();
    end
    checks++;
    if (ciph != 3) begin errors++; $display("FAIL cipher_pulses: got %0d expected 3", ciph); end
    checks++;
    if (tag != 1) begin errors++; $display("FAIL tag_pulses: got %0d expected 1", tag); end
    checks++;
    if (ends != 1) begin errors++; $display("FAIL end_pulses: got %0d expected 1", ends); end
  endtask
  task automatic test_stall();
    int n, stall, req1, ens_bad, end_n;
    do_reset();
    valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 2; stall = 0; req1 = 0; ens_bad = 0; end_n = 0;
    while (end_n == 0 && n < 200) begin
      if (d_req && d_block == 4'd1) begin
        req1++;
        if (d_ens) ens_bad++;
        valid = stall == 5;
        if (stall < 5) stall++;
      end else valid = 1'b1;
      if (d_end) end_n = n;
      step();
      n++;
    end
    valid = 1'b1;
    checks++;
    if (req1 != 6) begin errors++; $display("FAIL stall_req_cycles: got %0d expected 6", req1); end
    checks++;
    if (ens_bad != 0) begin errors++; $display("FAIL stall_en_state: got %0d expected 0", ens_bad); end
    checks++;
    if (end_n != 53) begin errors++; $display("FAIL stall_end_cycle: got %0d expected 53", end_n); end
  endtask
  task automatic test_no_ad();
    int n, end_n, xle, xdb, ciph;
    do_reset();
    valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 2; end_n = 0; xle = 0; xdb = 0; ciph = 0;
    while (end_n == 0 && n < 200) begin
      if (n == 13) begin
        checks++;
        if ({a_round, a_xke, a_xle} !== {4'd11, 2'b11}) begin
          errors++;
          $display("FAIL noad_init_last: got rnd=%0d xke=%b xle=%b expected rnd=11 xke=1 xle=1", a_round, a_xke, a_xle);
        end
      end
      if (n == 14) begin
        checks++;
        if ({a_req, a_block, a_ens} !== {1'b1, 4'd0, 1'b0}) begin
          errors++;
          $display("FAIL noad_wait_pt: got req=%b blk=%0d ens=%b expected req=1 blk=0 ens=0", a_req, a_block, a_ens);
        end
      end
      xle += int'(a_xle);
      xdb += int'(a_xdb);
      ciph += int'(a_ciph);
      if (a_end) end_n = n;
      step();
      n++;
    end
    checks++;
    if (xle != 1) begin errors++; $display("FAIL noad_lsb_pulses: got %0d expected 1", xle); end
    checks++;
    if (xdb != 3) begin errors++; $display("FAIL noad_xor_data: got %0d expected 3", xdb); end
    checks++;
    if (ciph != 3) begin errors++; $display("FAIL noad_cipher: got %0d expected 3", ciph); end
    checks++;
    if (end_n != 41) begin errors++; $display("FAIL noad_end_cycle: got %0d expected 41", end_n); end
  endtask
  task automatic test_reset_mid_final();
    int w, ends, n, end_n, tag;
    do_reset();
    valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    w = 0;
    while (d_xkb !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    repeat (4) step();
    checks++;
    if ({d_round, d_ens} !== {4'd4, 1'b1}) begin
      errors++;
      $display("FAIL final_round4: got rnd=%0d ens=%b expected rnd=4 ens=1", d_round, d_ens);
    end
    resetb = 1'b0;
    step();
    resetb = 1'b1;
    checks++;
    if ({d_round, d_block, d_fl} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid_final: got %h expected 0", {d_round, d_block, d_fl});
    end
    ends = 0;
    repeat (60) begin
      ends += int'(d_end);
      step();
    end
    checks++;
    if (ends != 0) begin errors++; $display("FAIL end_after_reset: got %0d expected 0", ends); end
    start = 1'b1;
    step();
    start = 1'b0;
    n = 2; end_n = 0; tag = 0;
    while (end_n == 0 && n < 200) begin
      tag += int'(d_tag);
      if (d_end) end_n = n;
      step();
      n++;
    end
    checks++;
    if (end_n != 48) begin errors++; $display("FAIL restart_end_cycle: got %0d expected 48", end_n); end
    checks++;
    if (tag != 1) begin errors++; $display("FAIL restart_tag: got %0d expected 1", tag); end
  endtask
  task automatic test_start_held();
    int n, end_n, inits;
    do_reset();
    valid = 1'b1;
    start = 1'b1;
    step();
    n = 2; end_n = 0; inits = 0;
    while (end_n == 0 && n < 200) begin
      inits += int'(d_init);
      if (d_end) end_n = n;
      step();
      n++;
    end
    checks++;
    if (end_n != 48) begin errors++; $display("FAIL held_end_cycle: got %0d expected 48", end_n); end
    checks++;
    if (inits != 1) begin errors++; $display("FAIL held_single_flow: got %0d inits expected 1", inits); end
    checks++;
    if (d_busy !== 1'b0) begin errors++; $display("FAIL held_idle_after_done: busy got %b expected 0", d_busy); end
    step();
    checks++;
    if ({d_busy, d_init} !== 2'b11) begin
      errors++;
      $display("FAIL held_restart: got busy=%b init=%b expected 1 1", d_busy, d_init);
    end
    do_reset();
  endtask
  task automatic test_short_cfg();
    int n, end_n, xdb, ciph;
    logic [3:0] er;
    do_reset();
    valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 2; end_n = 0; xdb = 0; ciph = 0;
    while (end_n == 0 && n < 100) begin
      if ((n >= 2 && n <= 9) || (n >= 11 && n <= 14) || (n >= 16 && n <= 23)) begin
        er = n <= 9 ? 4'(n - 2) : n <= 14 ? 4'(n - 7) : 4'(n - 16);
        checks++;
        if ({s_round, s_ens} !== {er, 1'b1}) begin
          errors++;
          $display("FAIL short_round c%0d: got rnd=%0d ens=%b expected rnd=%0d ens=1", n, s_round, s_ens, er);
        end
      end
      xdb += int'(s_xdb);
      ciph += int'(s_ciph);
      if (s_end) end_n = n;
      step();
      n++;
    end
    checks++;
    if (end_n != 24) begin errors++; $display("FAIL short_end_cycle: got %0d expected 24", end_n); end
    checks++;
    if (xdb != 2) begin errors++; $display("FAIL short_xor_data: got %0d expected 2", xdb); end
    checks++;
    if (ciph != 1) begin errors++; $display("FAIL short_cipher: got %0d expected 1", ciph); end
  endtask
  initial begin
    test_reset();
    test_full_flow();
    test_stall();
    test_no_ad();
    test_reset_mid_final();
    test_start_held();
    test_short_cfg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
